// File: rtl/reg_fl_sb.sv
// reg_fl_sb: parameterised register file for the decode stage.
// It has two combinational read ports, one WB write port, an optional
// hardwired zero register, optional write-to-read bypass, and a
// per-register pending scoreboard that feeds the hazard unit.
// After reset, a clear sequencer sweeps every register to zero.
module reg_fl_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            RES_VLD,
  input  logic [AW-1:0]   RES_A,
  output logic            PEND1,
  output logic            PEND2,
  output logic            busy
);

  localparam int            NREGS    = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [0:0]    S_CLEAR  = 1'b0;
  localparam logic [0:0]    S_RUN    = 1'b1;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic             busy_q, busy_d;
  logic [NREGS-1:0] pending_q, pending_d;

  logic run, wr_ok, res_ok, byp1, byp2;

  assign run    = (state_q == S_RUN);
  // A write or reservation aimed at the hardwired zero register is dropped.
  assign wr_ok  = run && WE3 && !(ZERO_REG && (A3 == '0));
  assign res_ok = run && RES_VLD && !(ZERO_REG && (RES_A == '0));
  assign byp1   = BYPASS && wr_ok && (A3 == A1);
  assign byp2   = BYPASS && wr_ok && (A3 == A2);
  assign busy   = busy_q;

  // Clear-sweep sequencing: walk clr_idx up to the last register, then enter RUN
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    if (state_q == S_CLEAR) begin
      if (clr_idx_q == LAST_IDX) begin
        state_d = S_RUN;
        busy_d  = 1'b0;
      end else begin
        clr_idx_d = clr_idx_q + AW'(1);
      end
    end
  end

  // Scoreboard update: the retiring write clears, and a new reservation sets (set wins)
  always_comb begin
    pending_d = pending_q;
    if (run && WE3) pending_d[A3] = 1'b0;
    if (res_ok)     pending_d[RES_A] = 1'b1;
  end

  // Control and scoreboard state, with synchronous reset into the clear sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // Register storage: the sweep zeroes one entry per cycle, and RUN takes WB writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR)
        regs_q[clr_idx_q] <= '0;
      else if (wr_ok)
        regs_q[A3] <= WD3;
    end
  end

  // Read port 1: forced to zero while clearing, then zero-reg, bypass, or array
  always_comb begin
    RD1 = '0;
    if (run && !(ZERO_REG && (A1 == '0)))
      RD1 = byp1 ? WD3 : regs_q[A1];
  end

  // Read port 2: resolved independently of port 1
  always_comb begin
    RD2 = '0;
    if (run && !(ZERO_REG && (A2 == '0)))
      RD2 = byp2 ? WD3 : regs_q[A2];
  end

  // Pending flags: a same-cycle write hides the hazard when the value is forwarded
  always_comb begin
    PEND1 = run && pending_q[A1] && !(BYPASS && WE3 && (A3 == A1));
    PEND2 = run && pending_q[A2] && !(BYPASS && WE3 && (A3 == A2));
  end

endmodule
